// File: rtl/cp0_unit.sv
// Coprocessor-0 exception controller: SR/Cause/EPC/PRId, interrupt vs exception
// arbitration, mfc0/mtc0/eret service. Req is the pipeline flush/redirect request.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h0000_4D50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] WD,
  input  logic        CP0Write,
  input  logic [31:0] VPC,
  input  logic        BD_in,
  input  logic [4:0]  ExcCode_in,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] RD,
  output logic [31:0] EPC_out,
  output logic        Req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic int_req;
  logic exc_req;
  logic sr_wr;
  logic epc_wr;

  assign int_req = (|(HWInt & im)) & ie & ~exl;
  assign exc_req = (ExcCode_in != 5'd0) & ~exl;
  // Gated by reset so no flush is requested while the block is being reset.
  assign Req     = reset & (int_req | exc_req);

  assign sr_wr   = CP0Write & (A2 == ADDR_SR);
  assign epc_wr  = CP0Write & (A2 == ADDR_EPC);

  always_ff @(posedge clk) begin
    if (!reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        exl      <= 1'b1;
        exc_code <= int_req ? 5'd0 : ExcCode_in;
        bd       <= BD_in;
        epc      <= BD_in ? (VPC - 32'd4) : VPC;
      end else begin
        // eret overrides the EXL bit of a simultaneous SR write.
        if (sr_wr) begin
          im  <= WD[15:10];
          ie  <= WD[0];
          exl <= WD[1] & ~EXLClr;
        end else if (EXLClr) begin
          exl <= 1'b0;
        end
        if (epc_wr) epc <= WD;
      end
    end
  end

  always_comb begin
    RD = '0;
    case (A1)
      ADDR_SR:    RD = {16'b0, im, 8'b0, exl, ie};
      ADDR_CAUSE: RD = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
      ADDR_EPC:   RD = epc;
      ADDR_PRID:  RD = PRID;
      default:    RD = '0;
    endcase
  end

  assign EPC_out = epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed walk through the exception scenarios, then random
// traffic compared against a word-level model of SR/Cause/EPC.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h0000_4D50;

  logic        clk;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] WD;
  logic        CP0Write;
  logic [31:0] VPC;
  logic        BD_in;
  logic [4:0]  ExcCode_in;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] RD;
  logic [31:0] EPC_out;
  logic        Req;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Model state held as whole architectural words.
  logic [31:0] m_sr, m_cause, m_epc;

  cp0_unit #(.PRID(PRID)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .WD(WD), .CP0Write(CP0Write),
    .VPC(VPC), .BD_in(BD_in), .ExcCode_in(ExcCode_in), .HWInt(HWInt),
    .EXLClr(EXLClr), .RD(RD), .EPC_out(EPC_out), .Req(Req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  function automatic logic m_int();
    return reset && (|(HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return reset && !m_sr[1] && (m_int() || ExcCode_in != 5'd0);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic req, intr;
    req  = m_req();
    intr = m_int();
    if (!reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
      if (req) begin
        m_sr    = m_sr | 32'h2;
        m_cause = (m_cause & ~32'h8000_007C) | (32'(BD_in) << 31)
                  | (intr ? 32'h0 : 32'(ExcCode_in) << 2);
        m_epc   = BD_in ? VPC - 32'd4 : VPC;
      end else begin
        if (CP0Write && A2 == 5'd12) m_sr = WD & 32'h0000_FC03;
        if (CP0Write && A2 == 5'd14) m_epc = WD;
        if (EXLClr) m_sr = m_sr & ~32'h2;
      end
    end
  endtask

  // Compare combinational outputs mid-cycle, then advance model and DUT together.
  task automatic cyc(input bit full);
    @(negedge clk);
    chk("req", {31'b0, Req}, {31'b0, m_req()});
    if (full) begin
      chk("rd", RD, m_rd(A1));
      chk("epc_out", EPC_out, m_epc);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    CP0Write = 0; A2 = 0; WD = 0; EXLClr = 0;
    ExcCode_in = 0; BD_in = 0;
  endtask

  task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
    A1 = a;
    @(negedge clk);
    chk(tag, RD, exp);
    @(posedge clk);
    #1;
    cyc(1);
  endtask

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    idle();
    A1 = 12; VPC = 0; HWInt = 6'h3F; ExcCode_in = 4; reset = 0;
    repeat (2) cyc(0);
    reset = 1; HWInt = 0; ExcCode_in = 0;
    #1;
    chk("req_after_rst", {31'b0, Req}, 32'h0);
    peek("rst_sr", 12, 32'h0);
    peek("rst_cause", 13, 32'h0);
    peek("rst_epc", 14, 32'h0);
    peek("rst_prid", 15, PRID);

    // Interrupt entry
    CP0Write = 1; A2 = 12; WD = 32'h0000_0401; cyc(1);
    idle(); HWInt = 6'b000001; VPC = 32'h3010;
    #1 chk("int_req", {31'b0, Req}, 32'h1);
    cyc(1);
    #1 chk("int_req_masked", {31'b0, Req}, 32'h0);
    peek("int_sr", 12, 32'h0000_0403);
    peek("int_cause", 13, 32'h0000_0400);
    peek("int_epc", 14, 32'h0000_3010);

    // Delay-slot exception
    HWInt = 0; EXLClr = 1; cyc(1);
    idle(); ExcCode_in = 12; BD_in = 1; VPC = 32'h3024;
    #1 chk("ds_req", {31'b0, Req}, 32'h1);
    cyc(1);
    idle();
    peek("ds_cause", 13, 32'h8000_0030);
    peek("ds_epc", 14, 32'h0000_3020);

    // EXL masking, eret, pending interrupt re-raise
    ExcCode_in = 10;
    #1 chk("exl_mask", {31'b0, Req}, 32'h0);
    cyc(1);
    ExcCode_in = 0; HWInt = 6'b000001; EXLClr = 1;
    #1 chk("exl_mask_int", {31'b0, Req}, 32'h0);
    cyc(1);
    EXLClr = 0; A1 = 12;
    #1 chk("eret_sr", RD, 32'h0000_0401);
    chk("int_reraise", {31'b0, Req}, 32'h1);
    cyc(1);
    HWInt = 0; EXLClr = 1; cyc(1);

    // mtc0 EPC colliding with an exception
    idle(); CP0Write = 1; A2 = 14; WD = 32'h1234_5678; ExcCode_in = 4; VPC = 32'h3040;
    cyc(1);
    idle();
    peek("coll_epc", 14, 32'h0000_3040);
    A1 = 13;
    #1 chk("coll_exc", (RD >> 2) & 32'h1F, 32'd4);
    cyc(1);
    EXLClr = 1; cyc(1);

    // Same-cycle read returns pre-edge EPC
    idle(); CP0Write = 1; A2 = 14; WD = 32'hABCD_0000; A1 = 14;
    #1 chk("same_rd_old", RD, 32'h0000_3040);
    chk("same_epc_old", EPC_out, 32'h0000_3040);
    cyc(1);
    idle();
    #1 chk("same_rd_new", RD, 32'hABCD_0000);
    chk("same_epc_new", EPC_out, 32'hABCD_0000);
    cyc(1);

    // Wrap of VPC-4
    ExcCode_in = 1; BD_in = 1; VPC = 0; cyc(1);
    idle();
    peek("wrap_epc", 14, 32'hFFFF_FFFC);
    EXLClr = 1; cyc(1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 59) != 0);
      A1         = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      CP0Write   = ($urandom_range(0, 2) == 0);
      A2         = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      WD         = $urandom;
      VPC        = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
      BD_in      = 1'($urandom);
      ExcCode_in = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      HWInt      = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      EXLClr     = ($urandom_range(0, 4) == 0);
      cyc(1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
